// File: rtl/pc_sequencer.sv
// Purpose: LC2K fetch-front-end PC sequencer with redirect, halt/resume and a saturating issue counter.
// Latency: one cycle from redirect/accept/halt/resume to the updated registered outputs.
// Backpressure: a fetch is accepted only when pc_valid & out_ready; otherwise PC and count hold.
module pc_sequencer #(
    parameter int ADDR_W    = 32,
    parameter int RESET_VEC = 0,
    parameter int STEP      = 1,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    input  logic              resume,
    input  logic              out_ready,
    output logic              pc_valid,
    output logic [ADDR_W-1:0] pc_current,
    output logic [ADDR_W-1:0] pc_plus_one,
    output logic              halted,
    output logic [CNT_W-1:0]  issue_count
);

    // Reset vector and step are truncated to the PC width; all PC sums wrap modulo 2^ADDR_W.
    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc1_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              accept;

    // Next state, next PC and next count; redirect beats accept beats hold, and any
    // same-cycle accept/redirect is applied before a halt takes effect.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            S_BOOT: begin
                // No fetch is presented in BOOT, so a redirect here loads PC without issuing.
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                state_d = halt_req ? S_HALTED : S_RUN;
            end
            S_RUN: begin
                accept = out_ready;
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (accept) begin
                    pc_d = pc_q + STEP_A;
                end
                // A fetch presented alongside a redirect still counts as issued.
                if (accept && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (halt_req) begin
                    state_d = S_HALTED;
                end
            end
            S_HALTED: begin
                // A halt_req arriving with resume keeps the core parked.
                if (resume && !halt_req) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // State and datapath registers; pc_plus_one is registered alongside pc_current so both
    // are presented in the same cycle without an adder on the output path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_BOOT;
            pc_q    <= RST_PC;
            pc1_q   <= RST_PC + STEP_A;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pc1_q   <= pc_d + STEP_A;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_valid    = (state_q == S_RUN);
    assign halted      = (state_q == S_HALTED);
    assign pc_current  = pc_q;
    assign pc_plus_one = pc1_q;
    assign issue_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: three instances (default, 4-bit PC with reset vector 14, 3-bit counter)
// share one stimulus stream; directed scenarios use hand-derived constants, the random phase
// compares every cycle against a rule-level reference model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        resume;
    logic        out_ready;

    logic        d_valid, d_halted;
    logic [31:0] d_pc, d_pp1, d_cnt;
    logic        w_valid, w_halted;
    logic [3:0]  w_pc, w_pp1;
    logic [31:0] w_cnt;
    logic        c_valid, c_halted;
    logic [31:0] c_pc, c_pp1;
    logic [2:0]  c_cnt;

    int cmp  = 0;
    int errs = 0;

    // Reference model state per instance: phase 0 = booting, 1 = fetching, 2 = parked.
    int              ph  [3];
    longint unsigned mpc [3];
    longint unsigned mcnt[3];
    longint unsigned MASK[3] = '{64'hFFFF_FFFF, 64'hF, 64'hFFFF_FFFF};
    longint unsigned CMAX[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd7};
    longint unsigned RVEC[3] = '{64'd0, 64'd14, 64'd0};

    pc_sequencer u_dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .resume(resume), .out_ready(out_ready),
        .pc_valid(d_valid), .pc_current(d_pc), .pc_plus_one(d_pp1), .halted(d_halted),
        .issue_count(d_cnt)
    );

    pc_sequencer #(.ADDR_W(4), .RESET_VEC(14)) u_w4 (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc[3:0]),
        .halt_req(halt_req), .resume(resume), .out_ready(out_ready),
        .pc_valid(w_valid), .pc_current(w_pc), .pc_plus_one(w_pp1), .halted(w_halted),
        .issue_count(w_cnt)
    );

    pc_sequencer #(.CNT_W(3)) u_c3 (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .resume(resume), .out_ready(out_ready),
        .pc_valid(c_valid), .pc_current(c_pc), .pc_plus_one(c_pp1), .halted(c_halted),
        .issue_count(c_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                ph[i] = 0; mpc[i] = RVEC[i]; mcnt[i] = 0;
            end else if (ph[i] == 0) begin
                if (redirect_valid) mpc[i] = redirect_pc & MASK[i];
                ph[i] = halt_req ? 2 : 1;
            end else if (ph[i] == 1) begin
                if (out_ready && mcnt[i] < CMAX[i]) mcnt[i] = mcnt[i] + 1;
                if (redirect_valid) mpc[i] = redirect_pc & MASK[i];
                else if (out_ready) mpc[i] = (mpc[i] + 1) & MASK[i];
                if (halt_req) ph[i] = 2;
            end else begin
                if (resume && !halt_req) ph[i] = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0; resume = 1'b0; out_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (3) tick();
        cmp++;
        if ({d_valid, d_halted, d_pc, d_pp1, d_cnt} !== {1'b0, 1'b0, 32'd0, 32'd1, 32'd0}) begin
            errs++;
            $display("FAIL reset_state: got v=%b h=%b pc=%h pp1=%h cnt=%0d, want 0 0 0 1 0",
                     d_valid, d_halted, d_pc, d_pp1, d_cnt);
        end
        cmp++;
        if ({w_valid, w_pc, w_pp1} !== {1'b0, 4'd14, 4'd15}) begin
            errs++;
            $display("FAIL reset_vec_w4: got v=%b pc=%0d pp1=%0d, want 0 14 15", w_valid, w_pc, w_pp1);
        end
        reset = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 5; k++) begin
            tick();
            cmp++;
            if ({d_valid, d_pc, d_pp1, d_cnt} !== {1'b1, 32'(k), 32'(k + 1), 32'(k)}) begin
                errs++;
                $display("FAIL seq_%0d: got v=%b pc=%0d pp1=%0d cnt=%0d, want 1 %0d %0d %0d",
                         k, d_valid, d_pc, d_pp1, d_cnt, k, k + 1, k);
            end
        end
    endtask

    task automatic test_backpressure();
        bit rdy_pat[4] = '{1, 0, 0, 1};
        int exp_pc[4]  = '{6, 6, 6, 7};
        out_ready = 1'b1;
        tick();
        cmp++;
        if (d_pc !== 32'd5) begin
            errs++;
            $display("FAIL bp_start: got pc=%0d, want 5", d_pc);
        end
        for (int j = 0; j < 4; j++) begin
            out_ready = rdy_pat[j];
            tick();
            cmp++;
            if (d_pc !== 32'(exp_pc[j])) begin
                errs++;
                $display("FAIL bp_step_%0d: got pc=%0d, want %0d", j, d_pc, exp_pc[j]);
            end
        end
        cmp++;
        if (d_cnt !== 32'd7) begin
            errs++;
            $display("FAIL bp_count: got cnt=%0d, want 7", d_cnt);
        end
    endtask

    task automatic test_redirect();
        out_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        cmp++;
        if ({d_pc, d_pp1, d_cnt} !== {32'h40, 32'h41, 32'd10}) begin
            errs++;
            $display("FAIL redirect_accept: got pc=%h pp1=%h cnt=%0d, want 40 41 10", d_pc, d_pp1, d_cnt);
        end
        redirect_pc = 32'h50; out_ready = 1'b0;
        tick();
        cmp++;
        if ({d_pc, d_pp1, d_cnt} !== {32'h50, 32'h51, 32'd10}) begin
            errs++;
            $display("FAIL redirect_noaccept: got pc=%h pp1=%h cnt=%0d, want 50 51 10", d_pc, d_pp1, d_cnt);
        end
    endtask

    task automatic test_halt();
        redirect_valid = 1'b1; redirect_pc = 32'd12; out_ready = 1'b0;
        tick();
        redirect_valid = 1'b0; halt_req = 1'b1; out_ready = 1'b1;
        tick();
        cmp++;
        if ({d_halted, d_valid, d_pc, d_pp1, d_cnt} !== {1'b1, 1'b0, 32'd13, 32'd14, 32'd11}) begin
            errs++;
            $display("FAIL halt_enter: got h=%b v=%b pc=%0d pp1=%0d cnt=%0d, want 1 0 13 14 11",
                     d_halted, d_valid, d_pc, d_pp1, d_cnt);
        end
        for (int j = 0; j < 10; j++) begin
            redirect_valid = 1'b1; redirect_pc = $urandom; halt_req = 1'($urandom_range(0, 1));
            tick();
            cmp++;
            if ({d_halted, d_valid, d_pc, d_cnt} !== {1'b1, 1'b0, 32'd13, 32'd11}) begin
                errs++;
                $display("FAIL halt_hold_%0d: got h=%b v=%b pc=%0d cnt=%0d, want 1 0 13 11",
                         j, d_halted, d_valid, d_pc, d_cnt);
            end
        end
        redirect_valid = 1'b0; resume = 1'b1; halt_req = 1'b1;
        tick();
        cmp++;
        if (d_halted !== 1'b1) begin
            errs++;
            $display("FAIL resume_with_halt: got h=%b, want 1", d_halted);
        end
        halt_req = 1'b0; out_ready = 1'b0;
        tick();
        cmp++;
        if ({d_halted, d_valid, d_pc, d_cnt} !== {1'b0, 1'b1, 32'd13, 32'd11}) begin
            errs++;
            $display("FAIL resume: got h=%b v=%b pc=%0d cnt=%0d, want 0 1 13 11", d_halted, d_valid, d_pc, d_cnt);
        end
        out_ready = 1'b1;
        tick();
        resume = 1'b0;
        cmp++;
        if ({d_halted, d_valid, d_pc, d_cnt} !== {1'b0, 1'b1, 32'd14, 32'd12}) begin
            errs++;
            $display("FAIL resume_in_run: got h=%b v=%b pc=%0d cnt=%0d, want 0 1 14 12", d_halted, d_valid, d_pc, d_cnt);
        end
    endtask

    task automatic test_wrap();
        int seq[4] = '{14, 15, 0, 1};
        do_reset();
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            cmp++;
            if ({w_valid, w_pc, w_pp1} !== {1'b1, 4'(seq[j]), 4'(seq[j] + 1)}) begin
                errs++;
                $display("FAIL w4_seq_%0d: got v=%b pc=%0d pp1=%0d, want 1 %0d %0d",
                         j, w_valid, w_pc, w_pp1, seq[j], (seq[j] + 1) % 16);
            end
        end
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; out_ready = 1'b0;
        tick();
        redirect_valid = 1'b0; out_ready = 1'b1;
        cmp++;
        if ({d_pc, d_pp1} !== {32'hFFFF_FFFF, 32'd0}) begin
            errs++;
            $display("FAIL wrap32_top: got pc=%h pp1=%h, want ffffffff 0", d_pc, d_pp1);
        end
        tick();
        cmp++;
        if ({d_pc, d_pp1} !== {32'd0, 32'd1}) begin
            errs++;
            $display("FAIL wrap32_roll: got pc=%h pp1=%h, want 0 1", d_pc, d_pp1);
        end
    endtask

    task automatic test_saturate_and_midreset();
        do_reset();
        out_ready = 1'b1;
        tick();
        for (int n = 1; n <= 9; n++) begin
            tick();
            cmp++;
            if (c_cnt !== 3'((n > 7) ? 7 : n)) begin
                errs++;
                $display("FAIL sat_%0d: got cnt=%0d, want %0d", n, c_cnt, (n > 7) ? 7 : n);
            end
        end
        redirect_valid = 1'b1; redirect_pc = 32'd20; out_ready = 1'b0;
        tick();
        redirect_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        cmp++;
        if ({c_valid, c_halted, c_pc, c_cnt} !== {1'b0, 1'b0, 32'd0, 3'd0}) begin
            errs++;
            $display("FAIL midreset_run: got v=%b h=%b pc=%0d cnt=%0d, want 0 0 0 0", c_valid, c_halted, c_pc, c_cnt);
        end
        out_ready = 1'b1;
        tick();
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        cmp++;
        if ({d_valid, d_halted, d_pc, d_cnt} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
            errs++;
            $display("FAIL midreset_halted: got v=%b h=%b pc=%0d cnt=%0d, want 0 0 0 0", d_valid, d_halted, d_pc, d_cnt);
        end
    endtask

    task automatic test_boot();
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h30; out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        cmp++;
        if ({d_valid, d_pc, d_pp1, d_cnt} !== {1'b1, 32'h30, 32'h31, 32'd0}) begin
            errs++;
            $display("FAIL boot_redirect: got v=%b pc=%h pp1=%h cnt=%0d, want 1 30 31 0", d_valid, d_pc, d_pp1, d_cnt);
        end
        do_reset();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        cmp++;
        if ({d_valid, d_halted, d_pc} !== {1'b0, 1'b1, 32'd0}) begin
            errs++;
            $display("FAIL boot_halt: got v=%b h=%b pc=%0d, want 0 1 0", d_valid, d_halted, d_pc);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            reset          = ($urandom_range(0, 99) < 2);
            redirect_valid = ($urandom_range(0, 99) < 20);
            redirect_pc    = $urandom;
            halt_req       = ($urandom_range(0, 99) < 8);
            resume         = ($urandom_range(0, 99) < 30);
            out_ready      = ($urandom_range(0, 99) < 70);
            if (cyc % 50 == 0) redirect_pc = 32'hFFFF_FFFF;
            tick();
            for (int i = 0; i < 3; i++) begin
                longint unsigned av, ah, apc, app, ac;
                longint unsigned ev, eh, epp;
                case (i)
                    0:       begin av = d_valid; ah = d_halted; apc = d_pc; app = d_pp1; ac = d_cnt; end
                    1:       begin av = w_valid; ah = w_halted; apc = w_pc; app = w_pp1; ac = w_cnt; end
                    default: begin av = c_valid; ah = c_halted; apc = c_pc; app = c_pp1; ac = c_cnt; end
                endcase
                ev  = (ph[i] == 1) ? 1 : 0;
                eh  = (ph[i] == 2) ? 1 : 0;
                epp = (mpc[i] + 1) & MASK[i];
                cmp++;
                if (av !== ev || ah !== eh || apc !== mpc[i] || app !== epp || ac !== mcnt[i]) begin
                    errs++;
                    $display("FAIL rand_c%0d_i%0d: got v=%0d h=%0d pc=%h pp1=%h cnt=%0d, want %0d %0d %h %h %0d",
                             cyc, i, av, ah, apc, app, ac, ev, eh, mpc[i], epp, mcnt[i]);
                end
            end
        end
        clear_inputs();
        reset = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_saturate_and_midreset();
        test_boot();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
